// File: rtl/mips32_pkg.sv
`default_nettype none
// mips32_pkg -- shared types and constants for the MIPS32 hazard scoreboard.
// Revision: 1.0
package mips32_pkg;

  localparam int c_WB_LAT_MIN = 1;
  localparam int c_WB_LAT_MAX = 8;
  // Tracked rd field is sized for the largest register file supported (256).
  localparam int c_RD_W       = 8;

  typedef struct packed {
    logic              valid;
    logic [c_RD_W-1:0] rd;
  } entry_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips32_hazard_scoreboard_if.sv
`default_nettype none
// mips32_hazard_scoreboard_if -- issue/write-back/status bundle between decode and scoreboard.
// Revision: 1.0
interface mips32_hazard_scoreboard_if
  import mips32_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int CNT_W = 16
);

  localparam int IDX_W = idx_w(NREGS);

  logic             iss_valid;
  logic [IDX_W-1:0] iss_rs;
  logic [IDX_W-1:0] iss_rt;
  logic             iss_rs_used;
  logic             iss_rt_used;
  logic [IDX_W-1:0] iss_rd;
  logic             iss_wr;
  logic             iss_halt;
  logic             flush;
  logic             iss_ready;
  logic             wb_valid;
  logic [IDX_W-1:0] wb_rd;
  logic             halted;
  logic             drained;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output iss_valid, iss_rs, iss_rt, iss_rs_used, iss_rt_used, iss_rd, iss_wr, iss_halt, flush,
    input  iss_ready, wb_valid, wb_rd, halted, drained, stall_cnt
  );

  modport slave (
    input  iss_valid, iss_rs, iss_rt, iss_rs_used, iss_rt_used, iss_rd, iss_wr, iss_halt, flush,
    output iss_ready, wb_valid, wb_rd, halted, drained, stall_cnt
  );

endinterface
`default_nettype wire

// File: rtl/mips32_hazard_cmp.sv
`default_nettype none
// mips32_hazard_cmp -- flags a RAW hazard when a live source matches any presented entry.
// Revision: 1.0
module mips32_hazard_cmp
  import mips32_pkg::*;
#(
  parameter int IDX_W = 5,
  parameter int NENT  = 3
) (
  input  logic [IDX_W-1:0] i_rs,
  input  logic [IDX_W-1:0] i_rt,
  input  logic             i_rs_used,
  input  logic             i_rt_used,
  input  entry_t [NENT-1:0] i_ent,
  output logic             o_hazard
);

  logic w_rs_live;
  logic w_rt_live;

  // Register 0 is hard-wired, so reading it never depends on anything.
  assign w_rs_live = i_rs_used & (i_rs != '0);
  assign w_rt_live = i_rt_used & (i_rt != '0);

  always_comb begin
    o_hazard = 1'b0;
    for (int i = 0; i < NENT; i++) begin
      if (i_ent[i].valid &&
          ((w_rs_live && (i_ent[i].rd == c_RD_W'(i_rs))) ||
           (w_rt_live && (i_ent[i].rd == c_RD_W'(i_rt))))) begin
        o_hazard = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mips32_hazard_scoreboard.sv
`default_nettype none
// mips32_hazard_scoreboard -- in-order RAW scoreboard with HLT drain and stall counter.
// Optional macro MIPS32_SCB_FWD_EN bypasses the retiring stage. Revision: 1.0
module mips32_hazard_scoreboard
  import mips32_pkg::*;
#(
  parameter int NREGS  = 32,
  parameter int WB_LAT = 3,
  parameter int CNT_W  = 16
) (
  input logic                      clk1,
  input logic                      reset,
  mips32_hazard_scoreboard_if.slave bus
);

  localparam int IDX_W = idx_w(NREGS);
  localparam int c_LAT = (WB_LAT < c_WB_LAT_MIN) ? c_WB_LAT_MIN :
                         (WB_LAT > c_WB_LAT_MAX) ? c_WB_LAT_MAX : WB_LAT;
`ifdef MIPS32_SCB_FWD_EN
  localparam int c_NCHK = c_LAT - 1;
`else
  localparam int c_NCHK = c_LAT;
`endif

  entry_t [c_LAT-1:0] r_stage;
  entry_t [c_LAT-1:0] w_next;
  entry_t             w_new;
  logic               w_fire;
  logic               w_hazard;
  logic               w_any_live;
  logic               r_halted;
  logic [CNT_W-1:0]   r_stall_cnt;

  generate
    if (c_NCHK > 0) begin : g_cmp
      mips32_hazard_cmp #(
        .IDX_W (IDX_W),
        .NENT  (c_NCHK)
      ) u_cmp (
        .i_rs      (bus.iss_rs),
        .i_rt      (bus.iss_rt),
        .i_rs_used (bus.iss_rs_used),
        .i_rt_used (bus.iss_rt_used),
        .i_ent     (r_stage[c_NCHK-1:0]),
        .o_hazard  (w_hazard)
      );
    end else begin : g_no_cmp
      assign w_hazard = 1'b0;
    end
  endgenerate

  assign bus.iss_ready = ~w_hazard & ~r_halted;
  assign w_fire        = bus.iss_valid & bus.iss_ready;

  // Untracked issues enter as an all-zero bubble so wb_rd reads 0 when idle.
  always_comb begin
    w_new = '0;
    if (w_fire && bus.iss_wr && (bus.iss_rd != '0)) begin
      w_new.valid = 1'b1;
      w_new.rd    = c_RD_W'(bus.iss_rd);
    end
  end

  generate
    if (c_LAT > 1) begin : g_shift
      always_comb begin
        w_next = {r_stage[c_LAT-2:0], w_new};
        // A taken branch squashes the instruction issued one cycle earlier.
        if (bus.flush) begin
          w_next[1] = '0;
        end
      end
    end else begin : g_single
      assign w_next = w_new;
    end
  endgenerate

  always_ff @(posedge clk1) begin
    if (reset) begin
      r_stage <= '0;
    end else begin
      r_stage <= w_next;
    end
  end

  always_ff @(posedge clk1) begin
    if (reset) begin
      r_halted <= 1'b0;
    end else if (w_fire && bus.iss_halt) begin
      r_halted <= 1'b1;
    end
  end

  always_ff @(posedge clk1) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (bus.iss_valid && !bus.iss_ready && !r_halted && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  always_comb begin
    w_any_live = 1'b0;
    for (int i = 0; i < c_LAT; i++) begin
      w_any_live = w_any_live | r_stage[i].valid;
    end
  end

  assign bus.wb_valid  = r_stage[c_LAT-1].valid;
  assign bus.wb_rd     = r_stage[c_LAT-1].rd[IDX_W-1:0];
  assign bus.halted    = r_halted;
  assign bus.drained   = r_halted & ~w_any_live;
  assign bus.stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire
